slot_allocator: RTL and testbench
=================================

Name: slot_allocator

Overview:
- Free-list allocator for a pool of SLOTS identical resources (buffer entries, tags, channel IDs).
- Holds a registered occupancy bitmap and grants the lowest-numbered free slot on each accepted allocate request.
- Returns slots on a separate free port.
- Lowest-free-slot search is a trailing-ones count over the occupancy bitmap, using the library's trailingOnes primitive.
- Sits between requesting engines and the shared resource array.

Parameters:
- SLOTS, default 8: number of managed slots; legal range 2..256; need not be a power of two.
- IDX_W, default $clog2(SLOTS): width of slot index ports; derived, never overridden.
- CNT_W, default $clog2(SLOTS+1): width of the occupancy count.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- alloc_valid  input  1  requester wants a slot this cycle.
- alloc_ready  output  1  a free slot exists; equals !full.
- alloc_index  output  IDX_W  slot granted when alloc_valid && alloc_ready.
- free_valid  input  1  return slot free_index to the pool.
- free_index  input  IDX_W  slot being returned.
- in_use  output  CNT_W  number of currently allocated slots.
- full  output  1  in_use == SLOTS.
- empty  output  1  in_use == 0.
- err_double_free  output  1  sticky: a free targeted an unallocated slot.
- err_range  output  1  sticky: free_index >= SLOTS.
- err_clear  input  1  clears both sticky error flags.

Behaviour:
- State: used[SLOTS-1:0] bitmap (1 = allocated), in_use counter, two sticky error bits. All registered.
- Reset (synchronous, reset=1 at clock edge):
  - used=0, in_use=0, err_double_free=0, err_range=0.
  - Outputs after reset: alloc_ready=1, alloc_index=0, full=0, empty=1.
  - Reset overrides every other input in the same cycle. Reset mid-operation discards all allocations; no error is raised for in-flight frees.
- alloc_index:
  - Combinational from registered used: trailing-ones count of used, i.e. the index of the lowest clear bit.
  - Zero-latency grant: index presented in the same cycle alloc_ready is high.
  - When full=1, alloc_index is 0 (don't-care) and must not be consumed.
- Allocate fires when alloc_valid && alloc_ready. Next edge: used[alloc_index] <= 1.
- alloc_valid while full: no state change, no error; the requester holds alloc_valid until alloc_ready.
- Free accepted when free_valid && free_index < SLOTS && used[free_index]==1. Next edge: used[free_index] <= 0.
- Free of an unallocated slot: ignored; err_double_free <= 1.
- free_index >= SLOTS: ignored; err_range <= 1 (takes precedence over the double-free check).
- Simultaneous allocate and valid free in one cycle:
  - Both take effect; in_use unchanged.
  - Allocation uses the pre-free bitmap, so the freed slot is grantable from the next cycle only.
  - When full, a concurrent free does not make alloc_ready high that cycle; alloc_ready rises the next cycle.
  - The allocated slot is free in the current bitmap, so a concurrent free can never target it without flagging double-free.
- in_use arithmetic: +1 on allocate only, -1 on accepted free only, unchanged when both or neither occur.
  - Never wraps; by construction it stays within 0..SLOTS.
  - full and empty are decoded combinationally from in_use.
- err_clear:
  - Clears both flags next edge.
  - If an error event coincides with err_clear, the flag is set (set wins).
- Internal FSM: none beyond the bitmap. Implementation uses trailingOnes on used, gated by full because the count width cannot represent SLOTS.

Test Plan:
- SLOTS=4, reset, then alloc_valid held 5 cycles -> grants 0,1,2,3 on cycles 1-4. Cycle 5: alloc_ready=0, full=1, in_use=4, bitmap unchanged.
- SLOTS=4, all allocated, free_index=2 -> next cycle alloc_ready=1, alloc_index=2; allocate -> full=1 again.
- SLOTS=4, used=4'b1011, same cycle alloc (index 2) and free_index=0 -> next cycle used=4'b1110, in_use=3, alloc_index=0.
- SLOTS=4, used=4'b0001, free_index=3 -> err_double_free=1, used unchanged. Then err_clear=1 -> flag 0 next cycle.
- SLOTS=6, free_index=7 -> err_range=1, err_double_free stays 0, bitmap unchanged. Error coincident with err_clear -> flag reads 1.
- SLOTS=8, allocate 5 slots, assert reset mid-stream with alloc_valid=1 -> next cycle used=0, in_use=0, empty=1, alloc_index=0, no grant recorded.

Source files
------------

// File: rtl/slot_allocator.sv
// slot_allocator: free-list allocator for a pool of SLOTS identical resources.
// Keeps a registered occupancy bitmap and offers the lowest-numbered free slot
// every cycle; slots are handed back through a separate free port.
//
// Ports:
//   clk, reset       - single clock, synchronous active-high reset
//   alloc_valid      - requester wants a slot this cycle
//   alloc_ready      - a free slot exists (== !full)
//   alloc_index      - slot granted when alloc_valid && alloc_ready
//   free_valid       - return free_index to the pool
//   free_index       - slot being returned
//   in_use           - number of currently allocated slots
//   full / empty     - in_use == SLOTS / in_use == 0
//   err_double_free  - sticky: a free targeted an unallocated slot
//   err_range        - sticky: free_index >= SLOTS
//   err_clear        - clears both sticky flags (a coincident error wins)
module slot_allocator #(
  parameter int unsigned SLOTS = 8,
  parameter int unsigned IDX_W = $clog2(SLOTS),
  parameter int unsigned CNT_W = $clog2(SLOTS + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             alloc_valid,
  output logic             alloc_ready,
  output logic [IDX_W-1:0] alloc_index,
  input  logic             free_valid,
  input  logic [IDX_W-1:0] free_index,
  output logic [CNT_W-1:0] in_use,
  output logic             full,
  output logic             empty,
  output logic             err_double_free,
  output logic             err_range,
  input  logic             err_clear
);

  // Every value of free_index addresses a bit of the padded bitmap, so an
  // out-of-range index never reads outside the vector.
  localparam int unsigned PAD = 1 << IDX_W;

  logic [SLOTS-1:0] used;
  logic [PAD-1:0]   used_pad;
  logic [SLOTS-1:0] alloc_mask;
  logic [SLOTS-1:0] free_mask;
  logic             fire_alloc;
  logic             range_bad;
  logic             free_hit;
  logic             free_ok;
  logic             double_free;

  // Index of the lowest clear bit. With all bits set the result is not
  // representable in general, so the caller gates it with full.
  function automatic logic [IDX_W-1:0] trailing_ones(input logic [SLOTS-1:0] v);
    logic [IDX_W-1:0] n;
    logic             done;
    n    = '0;
    done = 1'b0;
    for (int unsigned i = 0; i < SLOTS; i++) begin
      if (!done && !v[i]) begin
        n    = IDX_W'(i);
        done = 1'b1;
      end
    end
    return n;
  endfunction

  assign full        = (in_use == CNT_W'(SLOTS));
  assign empty       = (in_use == '0);
  assign alloc_ready = !full;
  assign alloc_index = full ? '0 : trailing_ones(used);

  always_comb begin
    used_pad              = '0;
    used_pad[SLOTS-1:0]   = used;
  end

  assign fire_alloc  = alloc_valid && alloc_ready;
  assign range_bad   = free_valid && ({1'b0, free_index} >= (IDX_W + 1)'(SLOTS));
  assign free_hit    = used_pad[free_index];
  assign free_ok     = free_valid && !range_bad && free_hit;
  assign double_free = free_valid && !range_bad && !free_hit;

  // The granted slot is clear in the current bitmap, so it can never collide
  // with an accepted free in the same cycle.
  assign alloc_mask = fire_alloc ? (SLOTS'(1) << alloc_index) : '0;
  assign free_mask  = free_ok    ? (SLOTS'(1) << free_index)  : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      used            <= '0;
      in_use          <= '0;
      err_double_free <= 1'b0;
      err_range       <= 1'b0;
    end else begin
      used <= (used | alloc_mask) & ~free_mask;
      if (fire_alloc && !free_ok) begin
        in_use <= in_use + 1'b1;
      end else if (free_ok && !fire_alloc) begin
        in_use <= in_use - 1'b1;
      end
      err_double_free <= double_free | (err_double_free & ~err_clear);
      err_range       <= range_bad   | (err_range       & ~err_clear);
    end
  end

endmodule

// File: tb/tb_slot_allocator.sv
// Self-checking bench for slot_allocator (SLOTS=6, a non-power-of-two pool so
// out-of-range indices 6 and 7 are reachable). A slot-array model computes the
// expected outputs every cycle; directed steps pin literal values.
module tb_slot_allocator;

  localparam int S  = 6;
  localparam int IW = 3;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          alloc_valid = 1'b0;
  logic          free_valid = 1'b0;
  logic          err_clear = 1'b0;
  logic [IW-1:0] free_index = '0;
  logic          alloc_ready;
  logic [IW-1:0] alloc_index;
  logic [CW-1:0] in_use;
  logic          full;
  logic          empty;
  logic          err_double_free;
  logic          err_range;

  int vectors     = 0;
  int miscompares = 0;
  bit started     = 1'b0;

  // Model: one bit per slot plus the two sticky flags.
  bit mu [S];
  bit m_edbl;
  bit m_erng;
  int cmp_ff;
  int cmp_cnt;

  always #5 clk = ~clk;

  slot_allocator #(.SLOTS(S)) dut (
    .clk             (clk),
    .reset           (reset),
    .alloc_valid     (alloc_valid),
    .alloc_ready     (alloc_ready),
    .alloc_index     (alloc_index),
    .free_valid      (free_valid),
    .free_index      (free_index),
    .in_use          (in_use),
    .full            (full),
    .empty           (empty),
    .err_double_free (err_double_free),
    .err_range       (err_range),
    .err_clear       (err_clear)
  );

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < S; i++) c += int'(mu[i]);
    return c;
  endfunction

  function automatic int m_first_free();
    for (int i = 0; i < S; i++) if (!mu[i]) return i;
    return -1;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Advance the model with the inputs the DUT samples at this edge.
  task automatic model_step();
    int  ff;
    bit  grant, rng, dbl, ok;
    if (reset) begin
      for (int i = 0; i < S; i++) mu[i] = 1'b0;
      m_edbl = 1'b0;
      m_erng = 1'b0;
    end else begin
      ff    = m_first_free();
      grant = alloc_valid && (ff >= 0);
      rng   = free_valid && (int'(free_index) >= S);
      dbl   = free_valid && !rng && !mu[free_index];
      ok    = free_valid && !rng && mu[free_index];
      if (ok)    mu[free_index] = 1'b0;
      if (grant) mu[ff] = 1'b1;
      m_erng = rng || (m_erng && !err_clear);
      m_edbl = dbl || (m_edbl && !err_clear);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic drive(input bit av, input bit fv, input int fi, input bit ec, input bit rs);
    alloc_valid = av;
    free_valid  = fv;
    free_index  = IW'(fi);
    err_clear   = ec;
    reset       = rs;
  endtask

  // Outputs depend only on registered state, so mid-cycle sampling is stable.
  always @(negedge clk) begin
    if (started) begin
      cmp_ff  = m_first_free();
      cmp_cnt = m_count();
      chk("in_use",          in_use,          cmp_cnt);
      chk("full",            full,            cmp_cnt == S);
      chk("empty",           empty,           cmp_cnt == 0);
      chk("alloc_ready",     alloc_ready,     cmp_ff >= 0);
      chk("alloc_index",     alloc_index,     (cmp_ff < 0) ? 0 : cmp_ff);
      chk("err_double_free", err_double_free, m_edbl);
      chk("err_range",       err_range,       m_erng);
    end
  end

  initial begin
    drive(0, 0, 0, 0, 1);
    tick();
    started = 1'b1;
    drive(0, 0, 0, 0, 0);
    chk("rst_in_use", in_use, 0);
    chk("rst_empty", empty, 1);
    chk("rst_ready", alloc_ready, 1);
    chk("rst_index", alloc_index, 0);

    // Hold alloc_valid: grants 0..5, then full with no further change.
    drive(1, 0, 0, 0, 0);
    for (int i = 0; i < S; i++) begin
      chk("grant_seq", alloc_index, i);
      tick();
    end
    chk("fill_full", full, 1);
    chk("fill_ready", alloc_ready, 0);
    chk("fill_in_use", in_use, 6);
    tick();
    chk("full_hold_in_use", in_use, 6);

    // Free slot 2 from full: it becomes the next grant.
    drive(0, 1, 2, 0, 0); tick(); drive(0, 0, 0, 0, 0);
    chk("free2_ready", alloc_ready, 1);
    chk("free2_index", alloc_index, 2);
    chk("free2_in_use", in_use, 5);
    drive(1, 0, 0, 0, 0); tick(); drive(0, 0, 0, 0, 0);
    chk("refill_full", full, 1);

    // Free 0 and 1, then allocate slot 0 while freeing 3 (used -> 110101).
    drive(0, 1, 0, 0, 0); tick();
    drive(0, 1, 1, 0, 0); tick(); drive(0, 0, 0, 0, 0);
    chk("two_free_index", alloc_index, 0);
    chk("two_free_in_use", in_use, 4);
    drive(1, 1, 3, 0, 0); tick(); drive(0, 0, 0, 0, 0);
    chk("simul_in_use", in_use, 4);
    chk("simul_index", alloc_index, 1);

    // Double free of slot 3, then clear.
    drive(0, 1, 3, 0, 0); tick(); drive(0, 0, 0, 0, 0);
    chk("dbl_set", err_double_free, 1);
    chk("dbl_no_range", err_range, 0);
    chk("dbl_in_use", in_use, 4);
    drive(0, 0, 0, 1, 0); tick(); drive(0, 0, 0, 0, 0);
    chk("dbl_cleared", err_double_free, 0);

    // Range errors; coincident with err_clear the flag stays set.
    drive(0, 1, 7, 0, 0); tick(); drive(0, 0, 0, 0, 0);
    chk("rng_set", err_range, 1);
    chk("rng_no_dbl", err_double_free, 0);
    chk("rng_in_use", in_use, 4);
    drive(0, 1, 6, 1, 0); tick(); drive(0, 0, 0, 0, 0);
    chk("rng_set_wins", err_range, 1);
    drive(0, 0, 0, 1, 0); tick(); drive(0, 0, 0, 0, 0);
    chk("rng_cleared", err_range, 0);

    // Refill (slots 1 and 3), then free while full with alloc_valid high.
    drive(1, 0, 0, 0, 0); tick(); tick(); drive(0, 0, 0, 0, 0);
    chk("refill2_full", full, 1);
    drive(1, 1, 4, 0, 0);
    chk("full_free_ready_low", alloc_ready, 0);
    tick(); drive(0, 0, 0, 0, 0);
    chk("full_free_ready", alloc_ready, 1);
    chk("full_free_index", alloc_index, 4);
    chk("full_free_in_use", in_use, 5);

    // Reset mid-stream with alloc_valid asserted.
    drive(1, 0, 0, 0, 1); tick(); drive(0, 0, 0, 0, 0);
    chk("midrst_in_use", in_use, 0);
    chk("midrst_empty", empty, 1);
    chk("midrst_index", alloc_index, 0);
    tick();
    chk("midrst_no_grant", in_use, 0);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      bit av, fv, ec, rs;
      int fi;
      rs = ($urandom_range(0, 99) == 0);
      av = ($urandom_range(0, 2) != 0);
      fv = ($urandom_range(0, 1) == 1);
      fi = ($urandom_range(0, 9) == 0) ? int'($urandom_range(6, 7)) : int'($urandom_range(0, 5));
      ec = ($urandom_range(0, 15) == 0);
      drive(av, fv, fi, ec, rs);
      tick();
    end

    drive(0, 0, 0, 0, 0);
    tick();
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
